// File: rtl/zbt_pkg.sv
// zbt_pkg: shared ZBT frame-buffer constants, sideband types and address/lane helpers
package zbt_pkg;

    localparam int ZBT_ADDR_W   = 19;
    localparam int ZBT_DATA_W   = 36;
    localparam int PIX_W        = 9;
    localparam int PIX_PER_WORD = 4;

    typedef struct packed {
        logic       act;
        logic [1:0] lane;
    } pix_tag_t;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic blank;
    } sync_t;

    // Word address of pixel (x, y); the writer side uses the same mapping.
    function automatic logic [ZBT_ADDR_W-1:0] zbt_word_addr(input logic [9:0] x, input logic [9:0] y);
        return {1'b0, y, x[9:2]};
    endfunction

    // Lane 0 sits in the top bits of the word, lane 3 in the bottom bits.
    function automatic logic [PIX_W-1:0] lane_pixel(input logic [ZBT_DATA_W-1:0] word, input logic [1:0] lane);
        return PIX_W'(word >> (PIX_W * (PIX_PER_WORD - 1 - int'(lane))));
    endfunction

endpackage

// File: rtl/zbt_frame_reader_if.sv
// zbt_frame_reader_if: ZBT read-port bus between the display reader and the memory
interface zbt_frame_reader_if;
    import zbt_pkg::*;

    logic [ZBT_ADDR_W-1:0] zbt_read_addr;
    logic                  zbt_read_req;
    logic [ZBT_DATA_W-1:0] zbt_read_data;

    modport master (output zbt_read_addr, output zbt_read_req, input zbt_read_data);
    modport slave  (input zbt_read_addr, input zbt_read_req, output zbt_read_data);

endinterface

// File: rtl/zbt_delay_line.sv
// zbt_delay_line: fixed-depth shift register used to align sideband with ZBT read data
module zbt_delay_line #(
    parameter int W = 1,
    parameter int D = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] sr [D];

    // Shift one stage per clock; reset flushes every stage to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < D; i++) sr[i] <= '0;
        end else begin
            sr[0] <= d;
            for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
        end
    end

    assign q = sr[D-1];

endmodule

// File: rtl/zbt_frame_reader.sv
// zbt_frame_reader: issues one ZBT read per 4 active pixels and unpacks the words into a pixel stream
module zbt_frame_reader
    import zbt_pkg::*;
#(
    parameter int H_ACTIVE     = 1024,
    parameter int V_ACTIVE     = 768,
    parameter int READ_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [10:0]          hcount,
    input  logic [9:0]           vcount,
    input  logic                 hsync_in,
    input  logic                 vsync_in,
    input  logic                 blank_in,
    zbt_frame_reader_if.master   zbt,
    output logic [PIX_W-1:0]     pixel,
    output logic                 hsync_out,
    output logic                 vsync_out,
    output logic                 blank_out
);

    logic                  act;
    pix_tag_t              tag_in, tag_d;
    sync_t                 sync_in, sync_d;
    logic [ZBT_DATA_W-1:0] hold;

    assign act     = enable && (32'(hcount) < H_ACTIVE) && (32'(vcount) < V_ACTIVE);
    assign tag_in  = '{act: act, lane: hcount[1:0]};
    assign sync_in = '{hsync: hsync_in, vsync: vsync_in, blank: blank_in};

    // Address follows the scan every clock; only lane-0 active pixels are real reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zbt.zbt_read_addr <= '0;
            zbt.zbt_read_req  <= 1'b0;
        end else begin
            zbt.zbt_read_addr <= zbt_word_addr(hcount[9:0], vcount);
            zbt.zbt_read_req  <= act && (hcount[1:0] == 2'd0);
        end
    end

    zbt_delay_line #(.W($bits(pix_tag_t)), .D(READ_LATENCY)) u_tag_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (tag_in),
        .q     (tag_d)
    );

    zbt_delay_line #(.W($bits(sync_t)), .D(READ_LATENCY)) u_sync_dly (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (sync_in),
        .q     (sync_d)
    );

    // Lane 0 takes the fresh word and keeps it for lanes 1..3; inactive pixels are forced to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold      <= '0;
            pixel     <= '0;
            hsync_out <= 1'b0;
            vsync_out <= 1'b0;
            blank_out <= 1'b0;
        end else begin
            hold      <= (tag_d.act && tag_d.lane == 2'd0) ? zbt.zbt_read_data : hold;
            pixel     <= !tag_d.act ? '0 :
                         (tag_d.lane == 2'd0) ? lane_pixel(zbt.zbt_read_data, 2'd0) :
                         lane_pixel(hold, tag_d.lane);
            hsync_out <= sync_d.hsync;
            vsync_out <= sync_d.vsync;
            blank_out <= sync_d.blank | ~tag_d.act;
        end
    end

endmodule

// File: tb/tb_zbt_frame_reader.sv
// tb_zbt_frame_reader: randomized scan stimulus checked against a pixel-level reference model
module tb_zbt_frame_reader;
    import zbt_pkg::*;

    typedef struct packed {
        logic [8:0] pix;
        logic       hs;
        logic       vs;
        logic       bl;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [10:0] hcount = '0;
    logic [9:0]  vcount = '0;
    logic        hsync_in = 1'b0, vsync_in = 1'b0, blank_in = 1'b0;
    logic [8:0]  pixel;
    logic        hsync_out, vsync_out, blank_out;

    int          errors = 0;
    int          checks = 0;
    int unsigned seed;
    exp_t        exp_q[$];
    logic [35:0] last_word;
    logic [18:0] exp_addr;
    logic        exp_req;

    zbt_frame_reader_if zif();

    zbt_frame_reader #(.H_ACTIVE(1024), .V_ACTIVE(768), .READ_LATENCY(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .hcount    (hcount),
        .vcount    (vcount),
        .hsync_in  (hsync_in),
        .vsync_in  (vsync_in),
        .blank_in  (blank_in),
        .zbt       (zif.master),
        .pixel     (pixel),
        .hsync_out (hsync_out),
        .vsync_out (vsync_out),
        .blank_out (blank_out)
    );

    always #5 clk = ~clk;

    function automatic logic [35:0] mem_word(input logic [18:0] a);
        if (a == 19'h1F464) return {9'h1FF, 9'h000, 9'h0AA, 9'h155};
        return {a[3:0] ^ seed[3:0], (32'(a) * 32'h9E3779B1) ^ seed};
    endfunction

    // ZBT: registered address plus one data register, i.e. two clocks from scan position to data.
    always @(posedge clk) zif.zbt_read_data <= mem_word(zif.zbt_read_addr);

    task automatic flush_model();
        exp_q.delete();
        last_word = '0;
        repeat (2) exp_q.push_back('{9'd0, 1'b0, 1'b0, 1'b1});
    endtask

    task automatic drive(input logic en, input int h, input int v, input logic hs, input logic vs, input logic bl);
        exp_t e;
        bit   a;
        int   lane;
        enable   = en;
        hcount   = 11'(h);
        vcount   = 10'(v);
        hsync_in = hs;
        vsync_in = vs;
        blank_in = bl;
        a    = en && h < 1024 && v < 768;
        lane = h % 4;
        exp_addr = 19'(v * 256 + (h % 1024) / 4);
        exp_req  = a && lane == 0;
        if (a && lane == 0) last_word = mem_word(exp_addr);
        e.pix = a ? 9'(last_word >> (27 - 9 * lane)) : 9'd0;
        e.hs  = hs;
        e.vs  = vs;
        e.bl  = bl | !a;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({pixel, hsync_out, vsync_out, blank_out, zif.zbt_read_req, zif.zbt_read_addr} !== '0) begin
            errors++;
            $display("FAIL reset_state: got pix=%h hs=%b vs=%b bl=%b req=%b addr=%h want all 0",
                     pixel, hsync_out, vsync_out, blank_out, zif.zbt_read_req, zif.zbt_read_addr);
        end
        rst_n = 1'b1;
        flush_model();
        for (int h = 0; h < 8; h++) begin
            drive(1'b1, h, 0, 1'b1, 1'b0, 1'b0);
            e = exp_q.pop_front();
            checks++;
            if ({pixel, hsync_out, vsync_out, blank_out} !== {e.pix, e.hs, e.vs, e.bl}) begin
                errors++;
                $display("FAIL reset_release_out h=%0d: got %h/%b%b%b want %h/%b%b%b", h,
                         pixel, hsync_out, vsync_out, blank_out, e.pix, e.hs, e.vs, e.bl);
            end
            checks++;
            if ({zif.zbt_read_req, zif.zbt_read_addr} !== {exp_req, exp_addr}) begin
                errors++;
                $display("FAIL reset_release_req h=%0d: got req=%b addr=%h want req=%b addr=%h", h,
                         zif.zbt_read_req, zif.zbt_read_addr, exp_req, exp_addr);
            end
        end
    endtask

    task automatic test_known_word();
        exp_t       e;
        logic [8:0] obs[7];
        logic [8:0] want[4] = '{9'h1FF, 9'h000, 9'h0AA, 9'h155};
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, 400 + i, 500, 1'b0, 1'b0, 1'b0);
            if (i == 0) begin
                checks++;
                if (zif.zbt_read_addr !== 19'h1F464 || zif.zbt_read_req !== 1'b1) begin
                    errors++;
                    $display("FAIL known_addr: got addr=%h req=%b want addr=1f464 req=1",
                             zif.zbt_read_addr, zif.zbt_read_req);
                end
            end
            e = exp_q.pop_front();
            checks++;
            if ({pixel, hsync_out, vsync_out, blank_out} !== {e.pix, e.hs, e.vs, e.bl}) begin
                errors++;
                $display("FAIL known_out i=%0d: got %h/%b%b%b want %h/%b%b%b", i,
                         pixel, hsync_out, vsync_out, blank_out, e.pix, e.hs, e.vs, e.bl);
            end
            obs[i] = pixel;
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (obs[i+2] !== want[i]) begin
                errors++;
                $display("FAIL known_lane%0d: got %h want %h", i, obs[i+2], want[i]);
            end
        end
    endtask

    task automatic test_full_scan();
        exp_t e;
        int   v = int'($urandom_range(0, 767));
        int   nreq = 0;
        for (int h = 0; h < 1024; h++) begin
            drive(1'b1, h, v, 1'($urandom), 1'($urandom), 1'($urandom));
            e = exp_q.pop_front();
            checks++;
            if ({pixel, hsync_out, vsync_out, blank_out} !== {e.pix, e.hs, e.vs, e.bl}) begin
                errors++;
                $display("FAIL scan_out v=%0d h=%0d: got %h/%b%b%b want %h/%b%b%b", v, h,
                         pixel, hsync_out, vsync_out, blank_out, e.pix, e.hs, e.vs, e.bl);
            end
            checks++;
            if ({zif.zbt_read_req, zif.zbt_read_addr} !== {exp_req, exp_addr}) begin
                errors++;
                $display("FAIL scan_req h=%0d: got req=%b addr=%h want req=%b addr=%h", h,
                         zif.zbt_read_req, zif.zbt_read_addr, exp_req, exp_addr);
            end
            if (zif.zbt_read_req === 1'b1) begin
                checks++;
                if (zif.zbt_read_addr !== 19'(v * 256 + nreq)) begin
                    errors++;
                    $display("FAIL scan_addr_step n=%0d: got %h want %h", nreq, zif.zbt_read_addr, 19'(v * 256 + nreq));
                end
                nreq++;
            end
        end
        checks++;
        if (nreq != 256) begin
            errors++;
            $display("FAIL scan_req_count: got %0d want 256", nreq);
        end
    endtask

    task automatic test_inactive();
        exp_t e;
        int   hv[$];
        int   nreq = 0;
        for (int h = 1024; h < 1040; h++) hv.push_back(h * 1024 + int'(vcount));
        for (int h = 0; h < 12; h++) hv.push_back(h * 1024 + 768);
        for (int h = 500; h < 504; h++) hv.push_back(h * 1024 + 1000);
        for (int h = 1100; h < 1104; h++) hv.push_back(h * 1024 + 900);
        foreach (hv[i]) begin
            drive(1'b1, hv[i] / 1024, hv[i] % 1024, 1'($urandom), 1'($urandom), 1'b0);
            if (zif.zbt_read_req !== 1'b0) nreq++;
            e = exp_q.pop_front();
            checks++;
            if ({pixel, hsync_out, vsync_out, blank_out} !== {e.pix, e.hs, e.vs, e.bl}) begin
                errors++;
                $display("FAIL inactive_out i=%0d: got %h/%b%b%b want %h/%b%b%b", i,
                         pixel, hsync_out, vsync_out, blank_out, e.pix, e.hs, e.vs, e.bl);
            end
            checks++;
            if (zif.zbt_read_addr !== exp_addr) begin
                errors++;
                $display("FAIL inactive_addr i=%0d: got %h want %h", i, zif.zbt_read_addr, exp_addr);
            end
        end
        checks++;
        if (nreq != 0) begin
            errors++;
            $display("FAIL inactive_req_count: got %0d want 0", nreq);
        end
    endtask

    task automatic test_enable_drop();
        exp_t e;
        int   v = int'($urandom_range(0, 767));
        int   nreq = 0;
        for (int h = 0; h < 32; h++) begin
            drive(h < 10, h, v, 1'($urandom), 1'($urandom), 1'($urandom));
            if (h >= 10 && zif.zbt_read_req !== 1'b0) nreq++;
            e = exp_q.pop_front();
            checks++;
            if ({pixel, hsync_out, vsync_out, blank_out} !== {e.pix, e.hs, e.vs, e.bl}) begin
                errors++;
                $display("FAIL enable_drop_out h=%0d: got %h/%b%b%b want %h/%b%b%b", h,
                         pixel, hsync_out, vsync_out, blank_out, e.pix, e.hs, e.vs, e.bl);
            end
        end
        checks++;
        if (nreq != 0) begin
            errors++;
            $display("FAIL enable_drop_req: got %0d requests after drop want 0", nreq);
        end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        int   v = int'($urandom_range(0, 767));
        int   nz = 0;
        for (int h = 0; h < 6; h++) begin
            drive(1'b1, h, v, 1'b1, 1'b1, 1'b0);
            e = exp_q.pop_front();
            checks++;
            if ({pixel, hsync_out, vsync_out, blank_out} !== {e.pix, e.hs, e.vs, e.bl}) begin
                errors++;
                $display("FAIL pre_reset_out h=%0d: got %h/%b%b%b want %h/%b%b%b", h,
                         pixel, hsync_out, vsync_out, blank_out, e.pix, e.hs, e.vs, e.bl);
            end
        end
        hcount = 11'd6;
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({pixel, hsync_out, vsync_out, blank_out, zif.zbt_read_req, zif.zbt_read_addr} !== '0) begin
            errors++;
            $display("FAIL mid_reset_async: got pix=%h hs=%b vs=%b bl=%b req=%b addr=%h want all 0",
                     pixel, hsync_out, vsync_out, blank_out, zif.zbt_read_req, zif.zbt_read_addr);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;
        flush_model();
        for (int h = 6; h < 21; h++) begin
            drive(1'b1, h, v, 1'b1, 1'b0, 1'b0);
            if (h < 10 && pixel !== 9'd0) nz++;
            e = exp_q.pop_front();
            checks++;
            if ({pixel, hsync_out, vsync_out, blank_out} !== {e.pix, e.hs, e.vs, e.bl}) begin
                errors++;
                $display("FAIL post_reset_out h=%0d: got %h/%b%b%b want %h/%b%b%b", h,
                         pixel, hsync_out, vsync_out, blank_out, e.pix, e.hs, e.vs, e.bl);
            end
        end
        checks++;
        if (nz != 0) begin
            errors++;
            $display("FAIL post_reset_early_pixel: got %0d non-zero pixels before first load want 0", nz);
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   h = int'($urandom_range(0, 1099));
        int   v = int'($urandom_range(0, 799));
        logic en = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) en = ~en;
            if ($urandom_range(0, 63) == 0) h = int'($urandom_range(0, 1099));
            drive(en, h, v, 1'($urandom), 1'($urandom), 1'($urandom));
            e = exp_q.pop_front();
            checks++;
            if ({pixel, hsync_out, vsync_out, blank_out} !== {e.pix, e.hs, e.vs, e.bl}) begin
                errors++;
                $display("FAIL b2b_out i=%0d: got %h/%b%b%b want %h/%b%b%b", i,
                         pixel, hsync_out, vsync_out, blank_out, e.pix, e.hs, e.vs, e.bl);
            end
            checks++;
            if ({zif.zbt_read_req, zif.zbt_read_addr} !== {exp_req, exp_addr}) begin
                errors++;
                $display("FAIL b2b_req i=%0d: got req=%b addr=%h want req=%b addr=%h", i,
                         zif.zbt_read_req, zif.zbt_read_addr, exp_req, exp_addr);
            end
            h = (h + 1) % 1100;
            if (h == 0) v = (v + 1) % 800;
        end
    endtask

    initial begin
        seed = $urandom;
        zif.zbt_read_data = '0;
        #1;
        test_reset();
        test_known_word();
        test_full_scan();
        test_inactive();
        test_enable_drop();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
